// File: rtl/clause_preload_ctrl_if.sv
// Bus bundle between the preload sequencer and its environment: host start
// and counts, the two preload memory read ports, and the load-buffer feed.
interface clause_preload_ctrl_if #(
  parameter int NUM_ENGINE = 4,
  parameter int CNT_W      = 7,
  parameter int MEM_AW     = 12,
  parameter int NODE_W     = 32,
  parameter int PTR_W      = 16
);
  logic                        start_in;
  logic [NUM_ENGINE*CNT_W-1:0] cla_cnt_in;
  logic [NUM_ENGINE*CNT_W-1:0] ptr_cnt_in;
  logic                        hold_in;
  logic                        cla_mem_rd_en_out;
  logic [MEM_AW-1:0]           cla_mem_addr_out;
  logic [NODE_W-1:0]           cla_mem_rdata_in;
  logic                        ptr_mem_rd_en_out;
  logic [MEM_AW-1:0]           ptr_mem_addr_out;
  logic [PTR_W-1:0]            ptr_mem_rdata_in;
  logic [NODE_W-1:0]           clause_out;
  logic                        load_clause_out;
  logic [PTR_W-1:0]            ptr_out;
  logic                        load_ptr_out;
  logic                        load_change_engine_out;
  logic                        busy_out;
  logic                        done_out;
  logic                        error_out;

  modport master (
    input  start_in, cla_cnt_in, ptr_cnt_in, hold_in,
    input  cla_mem_rdata_in, ptr_mem_rdata_in,
    output cla_mem_rd_en_out, cla_mem_addr_out,
    output ptr_mem_rd_en_out, ptr_mem_addr_out,
    output clause_out, load_clause_out, ptr_out, load_ptr_out,
    output load_change_engine_out, busy_out, done_out, error_out
  );

  modport slave (
    output start_in, cla_cnt_in, ptr_cnt_in, hold_in,
    output cla_mem_rdata_in, ptr_mem_rdata_in,
    input  cla_mem_rd_en_out, cla_mem_addr_out,
    input  ptr_mem_rd_en_out, ptr_mem_addr_out,
    input  clause_out, load_clause_out, ptr_out, load_ptr_out,
    input  load_change_engine_out, busy_out, done_out, error_out
  );
endinterface

// File: rtl/clause_preload_ctrl.sv
// Preload sequencer: walks engines in order, reading each engine's clauses
// then pointers from the preload memories and feeding the load buffer with
// load strobes and an engine-advance flag aligned to the first load of
// every engine after engine 0.
module clause_preload_ctrl #(
  parameter int NUM_ENGINE = 4,
  parameter int CLQ_DEPTH  = 64,
  parameter int CNT_W      = $clog2(CLQ_DEPTH) + 1,
  parameter int MEM_AW     = 12,
  parameter int NODE_W     = 32,
  parameter int PTR_W      = 16
) (
  input logic                  clock,
  input logic                  reset,
  clause_preload_ctrl_if.master bus
);

  localparam int ENG_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(CLQ_DEPTH);
  localparam logic [ENG_W-1:0] LAST_ENG = ENG_W'(NUM_ENGINE - 1);

  typedef enum logic [2:0] {IDLE, CLA, PTR, ADV, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ENG_W-1:0]  eng_q, eng_d, eng_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [MEM_AW-1:0] cla_addr_q, cla_addr_d, ptr_addr_q, ptr_addr_d;
  logic              pending_q, pending_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  cla_cnt_q [NUM_ENGINE];
  logic [CNT_W-1:0]  ptr_cnt_q [NUM_ENGINE];
  logic              latch, overflow, advance, done_d;
  logic              cla_rd, ptr_rd, solo_chg;
  logic              load_clause_p1, load_ptr_p1, change_p1, done_p1;

  // First phase of an engine: clauses, else pointers, else an empty-engine slot.
  function automatic state_t entry_state(input logic [CNT_W-1:0] c,
                                         input logic [CNT_W-1:0] p);
    if (c != '0) return CLA;
    if (p != '0) return PTR;
    return ADV;
  endfunction

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign eng_next = eng_q + ENG_W'(1);

  // Any requested count beyond the queue depth rejects the whole start.
  always_comb begin
    overflow = 1'b0;
    for (int e = 0; e < NUM_ENGINE; e++) begin
      if (bus.cla_cnt_in[e*CNT_W +: CNT_W] > DEPTH ||
          bus.ptr_cnt_in[e*CNT_W +: CNT_W] > DEPTH)
        overflow = 1'b1;
    end
  end

  // Next-state, read strobes and counter updates.
  always_comb begin
    state_d    = state_q;
    eng_d      = eng_q;
    cnt_d      = cnt_q;
    cla_addr_d = cla_addr_q;
    ptr_addr_d = ptr_addr_q;
    pending_d  = pending_q;
    error_d    = error_q;
    latch      = 1'b0;
    advance    = 1'b0;
    done_d     = 1'b0;
    cla_rd     = 1'b0;
    ptr_rd     = 1'b0;
    solo_chg   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          latch      = 1'b1;
          eng_d      = '0;
          cnt_d      = '0;
          cla_addr_d = '0;
          ptr_addr_d = '0;
          pending_d  = 1'b0;
          error_d    = overflow;
          done_d     = overflow;
          if (!overflow)
            state_d = entry_state(bus.cla_cnt_in[0 +: CNT_W], bus.ptr_cnt_in[0 +: CNT_W]);
        end
      end
      CLA: begin
        if (!bus.hold_in) begin
          cla_rd     = 1'b1;
          cla_addr_d = cla_addr_q + MEM_AW'(1);
          pending_d  = 1'b0;
          cnt_d      = cnt_inc;
          if (cnt_inc == cla_cnt_q[eng_q]) begin
            if (ptr_cnt_q[eng_q] != '0) begin
              state_d = PTR;
              cnt_d   = '0;
            end else begin
              advance = 1'b1;
            end
          end
        end
      end
      PTR: begin
        if (!bus.hold_in) begin
          ptr_rd     = 1'b1;
          ptr_addr_d = ptr_addr_q + MEM_AW'(1);
          pending_d  = 1'b0;
          cnt_d      = cnt_inc;
          if (cnt_inc == ptr_cnt_q[eng_q])
            advance = 1'b1;
        end
      end
      ADV: begin
        if (!bus.hold_in) begin
          solo_chg = (eng_q != '0);
          advance  = 1'b1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (eng_q == LAST_ENG) begin
        state_d = FLUSH;
      end else begin
        eng_d     = eng_next;
        cnt_d     = '0;
        pending_d = 1'b1;
        state_d   = entry_state(cla_cnt_q[eng_next], ptr_cnt_q[eng_next]);
      end
    end
  end

  // Control state and the one-cycle-late load/change/done strobes (p1 stage).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      eng_q          <= '0;
      cnt_q          <= '0;
      cla_addr_q     <= '0;
      ptr_addr_q     <= '0;
      pending_q      <= 1'b0;
      error_q        <= 1'b0;
      load_clause_p1 <= 1'b0;
      load_ptr_p1    <= 1'b0;
      change_p1      <= 1'b0;
      done_p1        <= 1'b0;
    end else begin
      state_q        <= state_d;
      eng_q          <= eng_d;
      cnt_q          <= cnt_d;
      cla_addr_q     <= cla_addr_d;
      ptr_addr_q     <= ptr_addr_d;
      pending_q      <= pending_d;
      error_q        <= error_d;
      load_clause_p1 <= cla_rd;
      load_ptr_p1    <= ptr_rd;
      change_p1      <= solo_chg | ((cla_rd | ptr_rd) & pending_q);
      done_p1        <= done_d;
    end
  end

  // Per-engine counts captured on an accepted start.
  always_ff @(posedge clock) begin
    if (latch) begin
      for (int e = 0; e < NUM_ENGINE; e++) begin
        cla_cnt_q[e] <= bus.cla_cnt_in[e*CNT_W +: CNT_W];
        ptr_cnt_q[e] <= bus.ptr_cnt_in[e*CNT_W +: CNT_W];
      end
    end
  end

  assign bus.cla_mem_rd_en_out      = cla_rd;
  assign bus.cla_mem_addr_out       = cla_addr_q;
  assign bus.ptr_mem_rd_en_out      = ptr_rd;
  assign bus.ptr_mem_addr_out       = ptr_addr_q;
  assign bus.load_clause_out        = load_clause_p1;
  assign bus.clause_out             = load_clause_p1 ? bus.cla_mem_rdata_in : '0;
  assign bus.load_ptr_out           = load_ptr_p1;
  assign bus.ptr_out                = load_ptr_p1 ? bus.ptr_mem_rdata_in : '0;
  assign bus.load_change_engine_out = change_p1;
  assign bus.busy_out               = (state_q != IDLE);
  assign bus.done_out               = done_p1;
  assign bus.error_out              = error_q;

endmodule

// File: tb/tb_clause_preload_ctrl.sv
// Bench for clause_preload_ctrl: queue-based reference model plus directed
// literal scenarios and randomized runs with holds, resets and busy starts.
module tb_clause_preload_ctrl;

  localparam int NE = 4;
  localparam int CW = 7;
  localparam int AW = 12;
  localparam int DEPTH = 64;

  logic clock;
  logic reset;
  clause_preload_ctrl_if bus ();

  clause_preload_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  int         m_mode = 0;   // 0 idle, 1 running, 2 flush
  int         q[$];         // actions: kind*2 + change, kind 0 clause, 1 ptr, 2 empty
  logic [AW-1:0] m_ca = '0, m_pa = '0;
  bit         m_err = 0;
  bit         exp_lc = 0, exp_lp = 0, exp_chg = 0, exp_done = 0;
  logic [AW-1:0] exp_ca = '0, exp_pa = '0;

  // Event monitors.
  int clq[$];
  int load_cnt = 0;
  int rd_cnt   = 0;

  function automatic logic [31:0] cla_word(input logic [AW-1:0] a);
    return {20'hC1A5E, a};
  endfunction

  function automatic logic [15:0] ptr_word(input logic [AW-1:0] a);
    return {4'hB, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Preload memories: one-cycle read latency, garbage when not read.
  always @(posedge clock) begin
    bus.cla_mem_rdata_in <= bus.cla_mem_rd_en_out ? cla_word(bus.cla_mem_addr_out) : 32'($urandom);
    bus.ptr_mem_rdata_in <= bus.ptr_mem_rd_en_out ? ptr_word(bus.ptr_mem_addr_out) : 16'($urandom);
  end

  task automatic model_step();
    bit ovf;
    int a, c, p;
    exp_lc = 0; exp_lp = 0; exp_chg = 0; exp_done = 0;
    if (reset) begin
      m_mode = 0; q.delete(); m_ca = '0; m_pa = '0; m_err = 0;
    end else begin
      case (m_mode)
        0: if (bus.start_in) begin
          m_ca = '0; m_pa = '0; m_err = 0; ovf = 0;
          for (int e = 0; e < NE; e++) begin
            if (int'(bus.cla_cnt_in[e*CW +: CW]) > DEPTH) ovf = 1;
            if (int'(bus.ptr_cnt_in[e*CW +: CW]) > DEPTH) ovf = 1;
          end
          if (ovf) begin
            m_err = 1; exp_done = 1;
          end else begin
            q.delete();
            for (int e = 0; e < NE; e++) begin
              bit first;
              first = (e != 0);
              c = int'(bus.cla_cnt_in[e*CW +: CW]);
              p = int'(bus.ptr_cnt_in[e*CW +: CW]);
              for (int i = 0; i < c; i++) begin q.push_back(0 + int'(first)); first = 0; end
              for (int i = 0; i < p; i++) begin q.push_back(2 + int'(first)); first = 0; end
              if (c == 0 && p == 0) q.push_back(4 + int'(first));
            end
            m_mode = 1;
          end
        end
        1: if (!bus.hold_in) begin
          a = q.pop_front();
          if ((a >> 1) == 0) begin exp_lc = 1; exp_ca = m_ca; m_ca = m_ca + 1'b1; end
          if ((a >> 1) == 1) begin exp_lp = 1; exp_pa = m_pa; m_pa = m_pa + 1'b1; end
          exp_chg = a[0];
          if (q.size() == 0) m_mode = 2;
        end
        default: begin m_mode = 0; exp_done = 1; end
      endcase
    end
  endtask

  task automatic compare();
    bit crd, prd;
    crd = (m_mode == 1) && !bus.hold_in && q.size() > 0 && ((q[0] >> 1) == 0);
    prd = (m_mode == 1) && !bus.hold_in && q.size() > 0 && ((q[0] >> 1) == 1);
    chk("busy", 64'(bus.busy_out), 64'(m_mode != 0));
    chk("done", 64'(bus.done_out), 64'(exp_done));
    chk("error", 64'(bus.error_out), 64'(m_err));
    chk("load_clause", 64'(bus.load_clause_out), 64'(exp_lc));
    chk("clause_data", 64'(bus.clause_out), exp_lc ? 64'(cla_word(exp_ca)) : 64'd0);
    chk("load_ptr", 64'(bus.load_ptr_out), 64'(exp_lp));
    chk("ptr_data", 64'(bus.ptr_out), exp_lp ? 64'(ptr_word(exp_pa)) : 64'd0);
    chk("change", 64'(bus.load_change_engine_out), 64'(exp_chg));
    chk("cla_rd_en", 64'(bus.cla_mem_rd_en_out), 64'(crd));
    chk("ptr_rd_en", 64'(bus.ptr_mem_rd_en_out), 64'(prd));
    chk("cla_addr", 64'(bus.cla_mem_addr_out), 64'(m_ca));
    chk("ptr_addr", 64'(bus.ptr_mem_addr_out), 64'(m_pa));
    if (bus.load_clause_out) clq.push_back(cyc);
    if (bus.load_clause_out || bus.load_ptr_out) load_cnt++;
    if (bus.cla_mem_rd_en_out || bus.ptr_mem_rd_en_out) rd_cnt++;
  endtask

  // Single compare process: model advances at each edge, DUT checked mid-cycle.
  always begin
    @(posedge clock);
    cyc++;
    model_step();
    #7;
    compare();
  end

  task automatic set_counts(input int c0, c1, c2, c3, p0, p1, p2, p3);
    bus.cla_cnt_in = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    bus.ptr_cnt_in = {CW'(p3), CW'(p2), CW'(p1), CW'(p0)};
  endtask

  // Start accepted at the edge ending cycle T; returns at +2 of cycle T+1.
  task automatic pulse_start();
    @(posedge clock); #2;
    bus.start_in = 1'b1; bus.hold_in = 1'b0;
    @(posedge clock); #2;
    bus.start_in = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input bit rnd);
    bit fin;
    fin = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clock); #2;
      if (!bus.busy_out) begin
        bus.start_in = 1'b0; bus.hold_in = 1'b0; fin = 1;
        break;
      end
      if (rnd) begin
        bus.hold_in = ($urandom_range(0, 3) == 0);
        bus.start_in = ($urandom_range(0, 7) == 0);
        if (bus.start_in) set_counts(5, 5, 5, 5, 5, 5, 5, 5);
      end
    end
    chk("idle_timeout", 64'(fin), 64'd1);
  endtask

  initial begin
    int lc_t[8], ca_t[8], lp_t[8], pa_t[8], ch_t[8];
    int chg_n, ld_n, first_c, last_c, done_seen, rst_at;
    logic [NE*CW-1:0] rc, rp;

    bus.start_in = 1'b0; bus.hold_in = 1'b0;
    set_counts(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #2;
    chk("rst_busy", 64'(bus.busy_out), 64'd0);
    chk("rst_done", 64'(bus.done_out), 64'd0);
    chk("rst_error", 64'(bus.error_out), 64'd0);
    chk("rst_load", 64'({bus.load_clause_out, bus.load_ptr_out, bus.load_change_engine_out}), 64'd0);

    // Mixed load with hand-computed per-cycle expectations.
    set_counts(2, 1, 0, 0, 1, 0, 0, 2);
    lc_t = '{1, 1, 0, 1, 0, 0, 0, 0};
    ca_t = '{0, 1, 0, 2, 0, 0, 0, 0};
    lp_t = '{0, 0, 1, 0, 0, 1, 1, 0};
    pa_t = '{0, 0, 0, 0, 0, 1, 2, 0};
    ch_t = '{0, 0, 0, 1, 1, 1, 0, 0};
    pulse_start();
    for (int k = 2; k <= 9; k++) begin
      @(posedge clock); #4;
      chk("mix_lc", 64'(bus.load_clause_out), 64'(lc_t[k-2]));
      chk("mix_clause", 64'(bus.clause_out), lc_t[k-2] ? 64'(cla_word(AW'(ca_t[k-2]))) : 64'd0);
      chk("mix_lp", 64'(bus.load_ptr_out), 64'(lp_t[k-2]));
      chk("mix_ptr", 64'(bus.ptr_out), lp_t[k-2] ? 64'(ptr_word(AW'(pa_t[k-2]))) : 64'd0);
      chk("mix_chg", 64'(bus.load_change_engine_out), 64'(ch_t[k-2]));
      chk("mix_done", 64'(bus.done_out), 64'(k == 9));
      chk("mix_busy", 64'(bus.busy_out), 64'(k != 9));
    end

    // All-zero counts: three consecutive standalone changes, no loads.
    set_counts(0, 0, 0, 0, 0, 0, 0, 0);
    pulse_start();
    chg_n = 0; ld_n = 0; first_c = -1; last_c = -1; done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #4;
      if (bus.load_change_engine_out) begin
        chg_n++; if (first_c < 0) first_c = k; last_c = k;
      end
      if (bus.load_clause_out || bus.load_ptr_out) ld_n++;
      if (bus.done_out) done_seen++;
    end
    chk("zero_changes", 64'(chg_n), 64'd3);
    chk("zero_consecutive", 64'(last_c - first_c), 64'd2);
    chk("zero_loads", 64'(ld_n), 64'd0);
    chk("zero_done", 64'(done_seen), 64'd1);

    // Hold for two cycles after the first clause strobe.
    set_counts(3, 0, 0, 0, 0, 0, 0, 0);
    clq.delete();
    pulse_start();
    @(posedge clock); #2 bus.hold_in = 1'b1;
    @(posedge clock); #2;
    @(posedge clock); #2 bus.hold_in = 1'b0;
    wait_idle(50, 0);
    chk("hold_count", 64'(clq.size()), 64'd3);
    if (clq.size() == 3) begin
      chk("hold_gap1", 64'(clq[1] - clq[0]), 64'd3);
      chk("hold_gap2", 64'(clq[2] - clq[1]), 64'd1);
    end

    // Overflow rejects the start; a later valid start clears the flag.
    set_counts(0, 0, DEPTH + 1, 0, 0, 0, 0, 0);
    rd_cnt = 0;
    pulse_start();
    chk("ovf_error", 64'(bus.error_out), 64'd1);
    chk("ovf_done", 64'(bus.done_out), 64'd1);
    chk("ovf_busy", 64'(bus.busy_out), 64'd0);
    repeat (3) @(posedge clock);
    #2;
    chk("ovf_no_reads", 64'(rd_cnt), 64'd0);
    chk("ovf_sticky", 64'(bus.error_out), 64'd1);
    set_counts(1, 0, 0, 0, 0, 0, 0, 0);
    pulse_start();
    chk("ovf_cleared", 64'(bus.error_out), 64'd0);
    wait_idle(50, 0);

    // Reset in the cycle a clause strobe is issued.
    set_counts(5, 0, 0, 0, 0, 0, 0, 0);
    pulse_start();
    reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
    chk("rstmid_load", 64'(bus.load_clause_out), 64'd0);
    chk("rstmid_clause", 64'(bus.clause_out), 64'd0);
    chk("rstmid_busy", 64'(bus.busy_out), 64'd0);
    chk("rstmid_rd", 64'(bus.cla_mem_rd_en_out), 64'd0);
    set_counts(2, 0, 0, 0, 0, 0, 0, 0);
    pulse_start();
    chk("restart_rd", 64'(bus.cla_mem_rd_en_out), 64'd1);
    chk("restart_addr", 64'(bus.cla_mem_addr_out), 64'd0);
    wait_idle(50, 0);

    // Start pulsed while busy with different counts is ignored.
    set_counts(2, 1, 0, 0, 1, 0, 0, 2);
    load_cnt = 0;
    pulse_start();
    @(posedge clock); #2;
    bus.start_in = 1'b1; set_counts(7, 7, 7, 7, 7, 7, 7, 7);
    @(posedge clock); #2 bus.start_in = 1'b0;
    wait_idle(50, 0);
    chk("busy_start_loads", 64'(load_cnt), 64'd6);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      for (int e = 0; e < NE; e++) begin
        rc[e*CW +: CW] = ($urandom_range(0, 2) == 0) ? CW'(0) : CW'($urandom_range(1, 6));
        rp[e*CW +: CW] = ($urandom_range(0, 2) == 0) ? CW'(0) : CW'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 9) == 0) rc[$urandom_range(0, NE-1)*CW +: CW] = CW'($urandom_range(DEPTH + 1, 127));
      if (r == 7) rp = {NE{CW'(DEPTH)}};
      bus.cla_cnt_in = rc; bus.ptr_cnt_in = rp;
      pulse_start();
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12)) : -1;
      if (rst_at >= 0) begin
        repeat (rst_at) begin
          @(posedge clock); #2 bus.hold_in = ($urandom_range(0, 3) == 0);
        end
        reset = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
      end
      wait_idle(2000, 1);
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    repeat (3) @(posedge clock);
    #8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clause_preload_ctrl.md
Name: clause_preload_ctrl

Overview:
- Sequences the preprocessed clause/pointer image from two read-only preload memories into the per-engine latency load buffer.
- Walks engines 0..NUM_ENGINE-1 in order. For each engine it issues that engine's clauses, then its pointers, and drives the load-buffer controls `load_clause`, `load_ptr` and `load_change_engine` with the correct alignment.
- Sits between the preload memories/host start logic and the load buffer. It supports a hold input for stalling.

Parameters:
- NUM_ENGINE, 4: number of engines to load.
- CLQ_DEPTH, 64: maximum clauses (and maximum pointers) per engine.
- CNT_W, $clog2(CLQ_DEPTH)+1: width of a per-engine count; holds 0..CLQ_DEPTH.
- MEM_AW, 12: address width of each preload memory.

Ports:
- clock  input  1  system clock. Single clock domain, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_in  input  1  one-cycle start pulse. Ignored while busy_out=1.
- cla_cnt_in  input  NUM_ENGINE*CNT_W  clause count per engine; engine e at [e*CNT_W +: CNT_W]. Latched on accepted start.
- ptr_cnt_in  input  NUM_ENGINE*CNT_W  pointer count per engine; same packing. Latched on accepted start.
- hold_in  input  1  stall: while high, no new read and no standalone change pulse is issued.
- cla_mem_rd_en_out  output  1  clause memory read strobe.
- cla_mem_addr_out  output  MEM_AW  clause memory address.
- cla_mem_rdata_in  input  node_t  clause read data, valid 1 cycle after the strobe.
- ptr_mem_rd_en_out  output  1  pointer memory read strobe.
- ptr_mem_addr_out  output  MEM_AW  pointer memory address.
- ptr_mem_rdata_in  input  ptr_t  pointer read data, valid 1 cycle after the strobe.
- clause_out  output  node_t  clause to the load buffer; equals cla_mem_rdata_in when load_clause_out=1, else 0.
- load_clause_out  output  1  clause valid.
- ptr_out  output  ptr_t  pointer to the load buffer; equals ptr_mem_rdata_in when load_ptr_out=1, else 0.
- load_ptr_out  output  1  pointer valid.
- load_change_engine_out  output  1  advance-engine flag, aligned with the first load of engines 1..NUM_ENGINE-1.
- busy_out  output  1  high from the cycle after an accepted start until done.
- done_out  output  1  one-cycle completion pulse.
- error_out  output  1  sticky count-overflow flag; cleared by the next accepted start or by reset.

Behaviour:
- Reset: state IDLE; engine index 0; both addresses 0; all outputs 0; any in-flight read is discarded (no load emitted).
- States: IDLE, CLA, PTR, ADV, FLUSH.
- IDLE + start_in:
  - Latch the counts; reset both addresses and the engine index to 0; clear error_out.
  - If any count > CLQ_DEPTH: set error_out, pulse done_out next cycle, no reads, stay IDLE.
  - Otherwise enter engine 0.
- Entering engine e:
  - Go to CLA if cla_cnt[e] > 0; else PTR if ptr_cnt[e] > 0; else ADV.
  - Set change_pending = (e != 0).
- CLA: one clause read per non-held cycle. Address post-increments and runs continuously across engines (no per-engine base). After the cla_cnt[e]-th read, go to PTR if ptr_cnt[e] > 0, else to the next engine. No bubble between engines.
- PTR: same as CLA, using the pointer memory and ptr_cnt[e].
- ADV (empty engine, e > 0): when not held, emit a standalone change (load_change_engine_out=1 next cycle, with no load), then go to the next engine. For an empty engine 0, ADV emits nothing and takes 1 cycle.
- Change alignment: the first read of engine e (clause or pointer) carries change_pending. load_change_engine_out is asserted in the same cycle as the corresponding load_clause_out or load_ptr_out. change_pending then clears.
- Latency: each read strobe produces its load_*_out exactly 1 cycle later. Clause and pointer strobes are never issued in the same cycle.
- After the last engine's last read or ADV: FLUSH for 1 cycle (the final output appears here), then return to IDLE. done_out pulses and busy_out falls in the cycle after FLUSH.
- hold_in:
  - Freezes state, counters and change_pending.
  - A read already issued still produces its output the next cycle.
  - hold_in has no effect in IDLE or FLUSH.
- start_in while busy: ignored; latched counts are unchanged.
- Address wrap: addresses wrap modulo 2^MEM_AW silently.
- Reset mid-load: immediate return to IDLE; a pending output in the next cycle is suppressed.

Test Plan:
- Mixed load: cla_cnt={2,1,0,0}, ptr_cnt={1,0,0,2}, start at cycle T, first reads at T+1. Expected outputs:
  - T+2, T+3: clause addresses 0, 1.
  - T+4: pointer address 0.
  - T+5: clause address 2 with change.
  - T+6: standalone change.
  - T+7: pointer address 1 with change.
  - T+8: pointer address 2.
  - T+9: done_out=1, busy_out=0.
- All zero counts with NUM_ENGINE=4 -> exactly 3 standalone change pulses on consecutive cycles, 0 loads, then done_out.
- Hold: cla_cnt={3,0,0,0}, hold_in high for 2 cycles after the first strobe -> clause outputs at addresses 0, 1, 2 with a 2-cycle gap after the first; each address emitted exactly once.
- Overflow: cla_cnt[2]=CLQ_DEPTH+1 -> error_out=1, no rd_en ever, done_out pulse the next cycle. A following valid start clears error_out.
- Reset mid-load: assert reset in the cycle a clause strobe is issued -> no load_clause_out the next cycle; all outputs 0. A restart begins at address 0.
- start_in pulsed during busy with different counts -> ignored; output sequence identical to the no-pulse run.
